// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a first-word-fall-through byte FIFO, one pop per frame.
// Back-to-back frames pop in the final stop cycle, so a full FIFO drains at line rate.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic [15:0]           frame_count
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                r_state, w_state_next;
    logic [CNT_W-1:0]      r_baud_cnt, w_baud_cnt_next;
    logic [IDX_W-1:0]      r_bit_idx, w_bit_idx_next;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
    logic                  r_parity, w_parity_next;
    logic                  r_tx, w_tx_next;
    logic                  r_busy;
    logic [15:0]           r_frame_count;
    logic                  w_bit_tick;
    logic                  w_pop;
    logic                  w_frame_done;

    assign w_bit_tick = (r_state != IDLE) && (r_baud_cnt == BAUD_LAST);
    // rst_n gating keeps the FIFO from being popped while the transmitter is held in reset.
    assign w_pop = rst_n & enable & ~fifo_empty &
                   ((r_state == IDLE) | ((r_state == STOP) & w_bit_tick));

    assign fifo_rd_en  = w_pop;
    assign tx          = r_tx;
    assign busy        = r_busy;
    assign frame_count = r_frame_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_baud_cnt_next = '0;
        w_bit_idx_next  = r_bit_idx;
        w_shift_next    = r_shift;
        w_parity_next   = r_parity;
        w_frame_done    = 1'b0;
        w_tx_next       = 1'b1;

        if (r_state != IDLE && !w_bit_tick) begin
            w_baud_cnt_next = r_baud_cnt + 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (w_pop) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (w_bit_tick) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    w_shift_next   = r_shift >> 1;
                    w_bit_idx_next = r_bit_idx + 1'b1;
                    if (r_bit_idx == IDX_LAST) begin
                        w_bit_idx_next = '0;
                        w_state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_bit_tick) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_bit_tick) begin
                    w_frame_done = 1'b1;
                    w_state_next = w_pop ? START : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase

        if (w_pop) begin
            w_shift_next    = fifo_dout;
            w_parity_next   = ^fifo_dout;
            w_baud_cnt_next = '0;
            w_bit_idx_next  = '0;
        end

        // Line level is registered, so it is derived from the state being entered.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = w_parity_next;
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt    <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_parity      <= 1'b0;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_baud_cnt <= w_baud_cnt_next;
            r_bit_idx  <= w_bit_idx_next;
            r_shift    <= w_shift_next;
            r_parity   <= w_parity_next;
            r_tx       <= w_tx_next;
            r_busy     <= (w_state_next != IDLE);
            if (w_frame_done) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a small FIFO model feeds the default instance,
// a second instance with parity enabled is driven directly.
module tb_fifo_uart_tx;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        tx;
    logic        busy;
    logic [15:0] frame_count;

    logic        p_enable;
    logic [7:0]  p_dout;
    logic        p_empty;
    logic        p_rd_en;
    logic        p_tx;
    logic        p_busy;
    logic [15:0] p_frame_count;

    logic [7:0]  mem [0:15];
    logic [3:0]  rd_ptr;
    logic [3:0]  wr_ptr;

    int n_vec;
    int n_miss;

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
        .frame_count(frame_count)
    );

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut_par (
        .clk(clk), .rst_n(rst_n), .enable(p_enable), .fifo_dout(p_dout),
        .fifo_empty(p_empty), .fifo_rd_en(p_rd_en), .tx(p_tx), .busy(p_busy),
        .frame_count(p_frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_dout  = mem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_rd_en) rd_ptr <= rd_ptr + 4'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 4'd1;
    endtask

    // Called at the pop cycle (cycle 0); returns in cycle 40 of the frame.
    task automatic check_frame(input logic [7:0] b, input logic exp_pop_end, input int drop_at);
        logic [9:0] frm;
        frm = {1'b1, b, 1'b0};
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == drop_at) enable = 1'b0;
            #1;
            check_eq($sformatf("tx_%02h_c%0d", b, c), {31'd0, tx}, {31'd0, frm[(c-1)/4]});
            check_eq($sformatf("busy_%02h_c%0d", b, c), {31'd0, busy}, 32'd1);
            check_eq($sformatf("rd_en_%02h_c%0d", b, c), {31'd0, fifo_rd_en},
                     (c == 40) ? {31'd0, exp_pop_end} : 32'd0);
        end
    endtask

    initial begin
        logic [10:0] pfrm;
        n_vec    = 0;
        n_miss   = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        p_enable = 1'b0;
        p_dout   = 8'h00;
        p_empty  = 1'b1;
        rd_ptr   = 4'd0;
        wr_ptr   = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        check_eq("reset_tx", {31'd0, tx}, 32'd1);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check_eq("reset_count", {16'd0, frame_count}, 32'd0);
        rst_n = 1'b1;

        // Empty FIFO: nothing may happen.
        enable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check_eq($sformatf("empty_c%0d", c), {29'd0, fifo_rd_en, tx, busy}, 32'b010);
        end

        // Single byte 0xA5.
        @(negedge clk);
        push(8'hA5);
        #1;
        check_eq("a5_pop", {31'd0, fifo_rd_en}, 32'd1);
        check_frame(8'hA5, 1'b0, 0);
        @(negedge clk);
        check_eq("a5_count", {16'd0, frame_count}, 32'd1);
        check_eq("a5_idle_busy", {31'd0, busy}, 32'd0);
        check_eq("a5_idle_tx", {31'd0, tx}, 32'd1);

        // Back-to-back 0x00 then 0xFF: second pop in the last stop cycle.
        @(negedge clk);
        push(8'h00);
        push(8'hFF);
        #1;
        check_eq("b2b_pop", {31'd0, fifo_rd_en}, 32'd1);
        check_frame(8'h00, 1'b1, 0);
        check_frame(8'hFF, 1'b0, 0);
        @(negedge clk);
        check_eq("b2b_count", {16'd0, frame_count}, 32'd3);
        check_eq("b2b_idle_busy", {31'd0, busy}, 32'd0);

        // Enable dropped at cycle 10; second byte must stay in the FIFO.
        @(negedge clk);
        push(8'h3C);
        push(8'h55);
        #1;
        check_eq("en_pop", {31'd0, fifo_rd_en}, 32'd1);
        check_frame(8'h3C, 1'b0, 10);
        @(negedge clk);
        check_eq("en_busy41", {31'd0, busy}, 32'd0);
        check_eq("en_no_pop41", {31'd0, fifo_rd_en}, 32'd0);
        check_eq("en_left", {31'd0, fifo_empty}, 32'd0);
        check_eq("en_count", {16'd0, frame_count}, 32'd4);
        wr_ptr = rd_ptr;

        // Reset pulsed mid-frame; 0x96 is discarded, 0x81 goes next.
        @(negedge clk);
        push(8'h96);
        push(8'h81);
        enable = 1'b1;
        #1;
        check_eq("rst_pop", {31'd0, fifo_rd_en}, 32'd1);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_tx", {31'd0, tx}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_count", {16'd0, frame_count}, 32'd0);
        check_eq("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_repop", {31'd0, fifo_rd_en}, 32'd1);
        check_eq("rst_head", {24'd0, fifo_dout}, 32'h81);
        check_frame(8'h81, 1'b0, 0);
        @(negedge clk);
        check_eq("rst_count_after", {16'd0, frame_count}, 32'd1);
        enable = 1'b0;

        // Parity instance, byte 0x07: start, 1110_0000, parity 1, stop.
        pfrm = 11'b1_1_00000111_0;
        @(negedge clk);
        p_enable = 1'b1;
        p_dout   = 8'h07;
        p_empty  = 1'b0;
        #1;
        check_eq("par_pop", {31'd0, p_rd_en}, 32'd1);
        for (int c = 1; c <= 44; c++) begin
            @(negedge clk);
            p_empty = 1'b1;
            #1;
            check_eq($sformatf("par_tx_c%0d", c), {31'd0, p_tx}, {31'd0, pfrm[(c-1)/4]});
            check_eq($sformatf("par_busy_c%0d", c), {31'd0, p_busy}, 32'd1);
        end
        @(negedge clk);
        check_eq("par_busy45", {31'd0, p_busy}, 32'd0);
        check_eq("par_count", {16'd0, p_frame_count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter that drains the 8-bit byte FIFO and sends each byte as an asynchronous UART frame. It sits directly downstream of `fifo`. It connects to the FIFO's `data_out`, `empty` and `rd_en` and drives a single `tx` line off-chip. The block pops one byte per frame and supports back-to-back frames with no idle gap, so a full FIFO drains at line rate.

## Interface
- `DATA_WIDTH`, 8: bits per character; matches the FIFO word width.
- `CLKS_PER_BIT`, 4: `clk` cycles per serial bit; legal range 2–65535.
- `PARITY_EN`, 0: 1 inserts an even-parity bit between the last data bit and the stop bit.
- `clk  input  1`: single clock; all logic is on the rising edge.
- `rst_n  input  1`: asynchronous, active-low reset.
- `enable  input  1`: permission to start new frames.
- `fifo_dout  input  DATA_WIDTH`: FIFO head word. It is valid whenever `fifo_empty` is 0 (first-word-fall-through).
- `fifo_empty  input  1`: FIFO empty flag.
- `fifo_rd_en  output  1`: one-cycle pop strobe to the FIFO `rd_en`.
- `tx  output  1`: serial line; idles high.
- `busy  output  1`: high while a frame is on the line.
- `frame_count  output  16`: number of completed frames.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Pop condition `pop = enable & ~fifo_empty & (state==IDLE | (state==STOP & bit_tick))`.
  - `bit_tick` is the last cycle of a bit period, i.e. baud counter == `CLKS_PER_BIT-1`.
  - `fifo_rd_en = pop` is combinational and never asserted while `fifo_empty`=1.
- On a pop edge:
  - the shift register loads `fifo_dout`;
  - the parity register loads `^fifo_dout`;
  - the baud counter clears;
  - the bit index clears;
  - the next state is START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: `tx`=`shift[0]`, sent LSB first. On each `bit_tick`, shift right and increment the bit index. After bit `DATA_WIDTH-1`, go to PARITY if `PARITY_EN`, otherwise STOP.
- PARITY: `tx` = XOR of the data bits (even parity), for one bit period, then STOP.
- STOP: `tx`=1 for one bit period.
  - On `bit_tick`, `frame_count` increments; it wraps 65535→0 modulo 2^16.
  - Next state is START if `pop`, otherwise IDLE.
- `busy`=1 in START, DATA, PARITY and STOP; 0 in IDLE.
- `enable` deasserted mid-frame: the current frame completes normally and no further pop occurs.
- `fifo_empty` rising mid-frame has no effect on the frame in flight.
- Reset, asynchronous and at any time:
  - state=IDLE, `tx`=1, `busy`=0, `fifo_rd_en`=0, `frame_count`=0, baud counter=0, shift register=0.
  - A byte already popped is discarded and not re-requested.
- The baud counter is `$clog2(CLKS_PER_BIT)` bits wide and saturates at its terminal value through the `bit_tick` compare only; it never overflows.

## Timing
- Pop-to-line latency: the pop happens in cycle N, and `tx` falls at cycle N+1 (registered output).
- Frame length is `(DATA_WIDTH+2+PARITY_EN)*CLKS_PER_BIT` cycles, which is 40 with the defaults.
- Back-to-back frames: the next pop occurs in the final STOP cycle. The next start bit begins the following cycle, so there are zero idle cycles between frames.
- From IDLE with data available, there is exactly one IDLE cycle (the pop cycle) before START.
- `busy` and `tx` are registered. `fifo_rd_en` is combinational from registered state and the FIFO flags only.
- `frame_count` updates on the edge that ends STOP, coincident with `busy` falling, or with a new START on a back-to-back frame.

## Test plan
- Single byte, defaults, FIFO loaded with 0xA5 and `enable`=1:
  - pop cycle 0; `tx`=0 in cycles 1–4;
  - data bits 1,0,1,0,0,1,0,1 in 4-cycle slots over cycles 5–36;
  - `tx`=1 in cycles 37–40; `busy` high in cycles 1–40; `frame_count`=1 after cycle 40.
- Back-to-back, FIFO holding 0x00 and 0xFF:
  - second `fifo_rd_en` pulse in cycle 40;
  - second start bit in cycles 41–44;
  - no cycle with `tx`=1 between the stop bit and the start bit beyond the 4 stop cycles; `frame_count`=2 at cycle 80.
- Empty FIFO with `enable`=1 for 50 cycles: `fifo_rd_en` never asserts, `tx` stays 1, `busy` stays 0.
- `enable` dropped at cycle 10 of a frame:
  - the frame completes through cycle 40;
  - no pop occurs in cycle 40 despite `fifo_empty`=0;
  - `busy`=0 at cycle 41.
- `rst_n` pulsed low at cycle 20 mid-frame:
  - `tx`=1, `busy`=0 and `frame_count`=0 immediately;
  - after release with `enable`=1, the next FIFO byte is popped within 1 cycle.
- `PARITY_EN`=1, byte 0x07: parity slot (cycles 37–40) drives 1; stop bit in cycles 41–44; frame length 44.
